// File: rtl/regfile_access_seq_pkg.sv
// Shared types for the register-file access sequencer: FSM states, default widths
// and the latched instruction fields.
package regfile_access_seq_pkg;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int ADDRESS_WIDTH_DEF = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RES = 3'd3,
    WRITE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH_DEF-1:0] rs1;
    logic [ADDRESS_WIDTH_DEF-1:0] rs2;
    logic [ADDRESS_WIDTH_DEF-1:0] rd;
    logic                         use_rs2;
    logic                         wb;
  } instr_fields_t;

endpackage

// File: rtl/regfile_access_seq.sv
// Sequences one instruction through RF read, ALU handshake and RF write-back; 5 cycles min with wb, 3 without.
// Stalls in ISSUE until op_ready and in WAIT_RES until res_valid; instr_valid is ignored while busy.
module regfile_access_seq
  import regfile_access_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [ADDRESS_WIDTH-1:0] instr_rs1,
  input  logic [ADDRESS_WIDTH-1:0] instr_rs2,
  input  logic [ADDRESS_WIDTH-1:0] instr_rd,
  input  logic                     instr_use_rs2,
  input  logic                     instr_wb,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [DATA_WIDTH-1:0]    op_a,
  output logic [DATA_WIDTH-1:0]    op_b,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [DATA_WIDTH-1:0]    res_data,
  output logic                     rf_r_en_one,
  output logic                     rf_r_en_two,
  output logic [ADDRESS_WIDTH-1:0] rf_r_adrs_one,
  output logic [ADDRESS_WIDTH-1:0] rf_r_adrs_two,
  input  logic [DATA_WIDTH-1:0]    rf_r_data_one,
  input  logic [DATA_WIDTH-1:0]    rf_r_data_two,
  output logic                     rf_w_en,
  output logic [ADDRESS_WIDTH-1:0] rf_w_adrs,
  output logic [DATA_WIDTH-1:0]    rf_w_data,
  output logic                     busy
);

  state_t                r_state;
  instr_fields_t         r_instr;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [DATA_WIDTH-1:0] r_res;
  logic                  r_instr_ready;
  logic                  r_busy;
  logic                  r_op_valid;
  logic                  r_res_ready;
  logic                  r_rf_r_en_one;
  logic                  r_rf_r_en_two;
  logic                  r_rf_w_en;

  // Every output is a flop, so the RF sees nothing change around its negedge sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_instr       <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_res         <= '0;
      r_instr_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_op_valid    <= 1'b0;
      r_res_ready   <= 1'b0;
      r_rf_r_en_one <= 1'b0;
      r_rf_r_en_two <= 1'b0;
      r_rf_w_en     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_instr       <= '{rs1: instr_rs1, rs2: instr_rs2, rd: instr_rd,
                               use_rs2: instr_use_rs2, wb: instr_wb};
            r_instr_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_rf_r_en_one <= 1'b1;
            r_rf_r_en_two <= instr_use_rs2;
            r_state       <= READ;
          end
        end
        READ: begin
          r_op_a        <= rf_r_data_one;
          r_op_b        <= r_instr.use_rs2 ? rf_r_data_two : '0;
          r_rf_r_en_one <= 1'b0;
          r_rf_r_en_two <= 1'b0;
          r_op_valid    <= 1'b1;
          r_state       <= ISSUE;
        end
        ISSUE: begin
          if (op_ready) begin
            r_op_valid <= 1'b0;
            if (r_instr.wb) begin
              r_res_ready <= 1'b1;
              r_state     <= WAIT_RES;
            end else begin
              r_instr_ready <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= IDLE;
            end
          end
        end
        WAIT_RES: begin
          if (res_valid) begin
            r_res       <= res_data;
            r_res_ready <= 1'b0;
            r_rf_w_en   <= 1'b1;
            r_state     <= WRITE;
          end
        end
        WRITE: begin
          r_rf_w_en     <= 1'b0;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: begin
          r_op_valid    <= 1'b0;
          r_res_ready   <= 1'b0;
          r_rf_r_en_one <= 1'b0;
          r_rf_r_en_two <= 1'b0;
          r_rf_w_en     <= 1'b0;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready   = r_instr_ready;
  assign busy          = r_busy;
  assign op_valid      = r_op_valid;
  assign op_a          = r_op_a;
  assign op_b          = r_op_b;
  assign res_ready     = r_res_ready;
  assign rf_r_en_one   = r_rf_r_en_one;
  assign rf_r_en_two   = r_rf_r_en_two;
  assign rf_r_adrs_one = r_instr.rs1;
  assign rf_r_adrs_two = r_instr.rs2;
  assign rf_w_en       = r_rf_w_en;
  assign rf_w_adrs     = r_instr.rd;
  assign rf_w_data     = r_res;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Bench for regfile_access_seq: negedge register-file model around the DUT plus an
// architectural register-array reference model driven by randomized instructions.
`timescale 1ns/1ps
module tb_regfile_access_seq;
  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          instr_valid = 1'b0, instr_ready;
  logic [AW-1:0] instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0;
  logic          instr_use_rs2 = 1'b0, instr_wb = 1'b0;
  logic          op_valid, op_ready = 1'b0;
  logic [DW-1:0] op_a, op_b;
  logic          res_valid = 1'b0, res_ready;
  logic [DW-1:0] res_data = '0;
  logic          rf_r_en_one, rf_r_en_two, rf_w_en, busy;
  logic [AW-1:0] rf_r_adrs_one, rf_r_adrs_two, rf_w_adrs;
  logic [DW-1:0] rf_r_data_one, rf_r_data_two, rf_w_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wcount = 0;
  logic [AW-1:0] last_wadr = '0;
  logic [DW-1:0] last_wdat = '0;
  logic [DW-1:0] rf_mem [0:4095];
  logic [DW-1:0] model  [0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_access_seq dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .instr_use_rs2(instr_use_rs2), .instr_wb(instr_wb),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .rf_r_en_one(rf_r_en_one), .rf_r_en_two(rf_r_en_two),
    .rf_r_adrs_one(rf_r_adrs_one), .rf_r_adrs_two(rf_r_adrs_two),
    .rf_r_data_one(rf_r_data_one), .rf_r_data_two(rf_r_data_two),
    .rf_w_en(rf_w_en), .rf_w_adrs(rf_w_adrs), .rf_w_data(rf_w_data),
    .busy(busy)
  );

  // Register file: samples reads and performs writes on negedge, resets every entry to 0xF.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) rf_mem[i] <= 32'h0000_000F;
      rf_r_data_one <= '0;
      rf_r_data_two <= '0;
    end else begin
      if (rf_r_en_one) rf_r_data_one <= rf_mem[rf_r_adrs_one];
      if (rf_r_en_two) rf_r_data_two <= rf_mem[rf_r_adrs_two];
      if (rf_w_en) rf_mem[rf_w_adrs] <= rf_w_data;
    end
  end

  always @(negedge clk) begin
    if (!reset && rf_w_en) begin
      wcount    <= wcount + 1;
      last_wadr <= rf_w_adrs;
      last_wdat <= rf_w_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) model[i] = 32'h0000_000F;
  endtask

  // Drives one instruction through every handshake; returns what was observed.
  task automatic run_instr(
    input  logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
    input  logic use2, input logic wb, input int op_dly, input int res_dly,
    input  logic [DW-1:0] res, input logic poke,
    output logic ok, output logic en_two, output logic [AW-1:0] adr1,
    output logic [DW-1:0] oa, output logic [DW-1:0] ob,
    output logic stable, output logic busy_all, output int wlat);
    int n;
    int a;
    ok = 1'b1; en_two = 1'b0; adr1 = '0; oa = '0; ob = '0;
    stable = 1'b1; busy_all = 1'b1; wlat = 0;
    n = 0;
    while (!instr_ready && n < 20) begin tick(); n++; end
    if (!instr_ready) begin ok = 1'b0; return; end
    instr_valid = 1'b1; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
    instr_use_rs2 = use2; instr_wb = wb;
    tick();
    instr_valid = 1'b0;
    a = cyc;
    en_two = rf_r_en_two; adr1 = rf_r_adrs_one; busy_all = busy;
    n = 0;
    while (!op_valid && n < 10) begin tick(); n++; end
    if (!op_valid) begin ok = 1'b0; return; end
    oa = op_a; ob = op_b;
    for (int i = 0; i < op_dly; i++) begin
      if (poke) begin
        instr_valid = 1'b1; instr_rs1 = ~rs1; instr_rs2 = ~rs2; instr_rd = ~rd;
        res_valid = 1'b1; res_data = ~res;
      end
      tick();
      if (op_a !== oa || op_b !== ob || op_valid !== 1'b1) stable = 1'b0;
      busy_all &= busy;
    end
    instr_valid = 1'b0; res_valid = 1'b0;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    if (!wb) return;
    n = 0;
    while (!res_ready && n < 10) begin tick(); n++; end
    if (!res_ready) begin ok = 1'b0; return; end
    for (int i = 0; i < res_dly; i++) begin busy_all &= busy; tick(); end
    res_valid = 1'b1; res_data = res;
    tick();
    res_valid = 1'b0;
    if (!rf_w_en) ok = 1'b0;
    wlat = cyc - a;
    busy_all &= busy;
    tick();
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    model_reset();
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_instr_ready got=%b exp=1", instr_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({op_valid, res_ready, rf_r_en_one, rf_r_en_two, rf_w_en} !== 5'b0) begin
      failures++; $display("FAIL reset_enables got=%b exp=00000", {op_valid, res_ready, rf_r_en_one, rf_r_en_two, rf_w_en}); end
    checks++; if ({op_a, op_b, rf_w_data} !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", op_a, op_b, rf_w_data); end
    tick();
    @(negedge clk) reset = 1'b0;
    tick();
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_release_idle got=rdy%b busy%b exp=rdy1 busy0", instr_ready, busy); end
  endtask

  task automatic test_basic();
    logic ok, e2, st, ba; logic [AW-1:0] a1; logic [DW-1:0] oa, ob; int wl, w0;
    w0 = wcount;
    run_instr(12'd3, 12'd4, 12'd6, 1'b1, 1'b1, 0, 0, 32'h1E, 1'b0, ok, e2, a1, oa, ob, st, ba, wl);
    model[6] = 32'h1E;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_handshake got=%b exp=1", ok); end
    checks++; if (oa !== 32'hF || ob !== 32'hF) begin failures++; $display("FAIL basic_ops got=%h/%h exp=0000000f/0000000f", oa, ob); end
    checks++; if (a1 !== 12'd3 || e2 !== 1'b1) begin failures++; $display("FAIL basic_read got=adr%0d en2=%b exp=adr3 en2=1", a1, e2); end
    checks++; if (wl !== 3) begin failures++; $display("FAIL basic_write_latency got=%0d exp=3", wl); end
    checks++; if (wcount - w0 !== 1 || last_wadr !== 12'd6 || last_wdat !== 32'h1E) begin
      failures++; $display("FAIL basic_write got=n%0d adr%0d dat%h exp=n1 adr6 dat0000001e", wcount - w0, last_wadr, last_wdat); end
  endtask

  task automatic test_raw();
    logic ok, e2, st, ba; logic [AW-1:0] a1; logic [DW-1:0] oa, ob; int wl;
    run_instr(12'd0, 12'd0, 12'd5, 1'b0, 1'b1, 0, 0, 32'hDEADBEEF, 1'b0, ok, e2, a1, oa, ob, st, ba, wl);
    model[5] = 32'hDEADBEEF;
    run_instr(12'd5, 12'd0, 12'd0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, ok, e2, a1, oa, ob, st, ba, wl);
    checks++; if (ok !== 1'b1 || oa !== 32'hDEADBEEF) begin
      failures++; $display("FAIL raw_op_a got=%h ok=%b exp=deadbeef ok=1", oa, ok); end
  endtask

  task automatic test_no_rs2();
    logic ok, e2, st, ba; logic [AW-1:0] a1; logic [DW-1:0] oa, ob; int wl, w0;
    run_instr(12'd1, 12'd7, 12'd8, 1'b0, 1'b1, 0, 0, 32'h1234, 1'b0, ok, e2, a1, oa, ob, st, ba, wl);
    model[8] = 32'h1234;
    checks++; if (e2 !== 1'b0 || ob !== '0) begin failures++; $display("FAIL no_rs2 got=en2=%b opb=%h exp=en2=0 opb=0", e2, ob); end
    w0 = wcount;
    run_instr(12'd8, 12'd7, 12'd9, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, ok, e2, a1, oa, ob, st, ba, wl);
    checks++; if (ob !== '0 || oa !== 32'h1234) begin failures++; $display("FAIL no_wb_ops got=%h/%h exp=00001234/0", oa, ob); end
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL no_wb_idle got=rdy%b busy%b exp=rdy1 busy0", instr_ready, busy); end
    tick(); tick();
    checks++; if (wcount !== w0) begin failures++; $display("FAIL no_wb_write got=%0d exp=%0d", wcount, w0); end
  endtask

  task automatic test_stall();
    logic ok, e2, st, ba; logic [AW-1:0] a1; logic [DW-1:0] oa, ob; int wl, w0;
    logic [DW-1:0] r;
    r = $urandom;
    w0 = wcount;
    run_instr(12'd6, 12'd5, 12'd10, 1'b1, 1'b1, 6, 4, r, 1'b1, ok, e2, a1, oa, ob, st, ba, wl);
    checks++; if (ok !== 1'b1 || oa !== model[6] || ob !== model[5]) begin
      failures++; $display("FAIL stall_ops got=%h/%h exp=%h/%h", oa, ob, model[6], model[5]); end
    model[10] = r;
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL stall_stable got=%b exp=1", st); end
    checks++; if (ba !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", ba); end
    checks++; if (wl !== 13) begin failures++; $display("FAIL stall_latency got=%0d exp=13", wl); end
    checks++; if (wcount - w0 !== 1 || last_wadr !== 12'd10 || last_wdat !== r) begin
      failures++; $display("FAIL stall_write got=n%0d adr%0d dat%h exp=n1 adr10 dat%h", wcount - w0, last_wadr, last_wdat, r); end
  endtask

  task automatic test_reset_mid();
    logic ok, e2, st, ba; logic [AW-1:0] a1; logic [DW-1:0] oa, ob; int wl, w0;
    for (int k = 0; k < 2; k++) begin
      instr_valid = 1'b1; instr_rs1 = 12'd1; instr_rs2 = 12'd1; instr_rd = 12'd2;
      instr_use_rs2 = 1'b1; instr_wb = 1'b1;
      tick(); instr_valid = 1'b0;
      tick(); op_ready = 1'b1;
      tick(); op_ready = 1'b0;
      checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL rstmid_wait_res got=%b exp=1", res_ready); end
      if (k == 1) begin
        res_valid = 1'b1; res_data = 32'hBAD0_0000;
        tick(); res_valid = 1'b0;
        checks++; if (rf_w_en !== 1'b1) begin failures++; $display("FAIL rstmid_in_write got=%b exp=1", rf_w_en); end
      end
      w0 = wcount;
      reset = 1'b1;
      #1;
      checks++; if ({res_ready, rf_w_en, op_valid, busy, instr_ready} !== 5'b00001 || op_a !== '0) begin
        failures++; $display("FAIL rstmid_outputs_%0d got=%b opa=%h exp=00001 opa=0", k, {res_ready, rf_w_en, op_valid, busy, instr_ready}, op_a); end
      #2 reset = 1'b0;
      model_reset();
      res_valid = 1'b1; res_data = 32'hBAD0_0001;
      tick(); res_valid = 1'b0;
      tick();
      checks++; if (wcount !== w0) begin failures++; $display("FAIL rstmid_no_write_%0d got=%0d exp=%0d", k, wcount, w0); end
    end
    run_instr(12'd2, 12'd1, 12'd2, 1'b1, 1'b1, 0, 0, 32'h55, 1'b0, ok, e2, a1, oa, ob, st, ba, wl);
    model[2] = 32'h55;
    checks++; if (ok !== 1'b1 || oa !== 32'hF || last_wadr !== 12'd2 || last_wdat !== 32'h55) begin
      failures++; $display("FAIL rstmid_recover got=ok%b opa%h adr%0d dat%h exp=ok1 opa0000000f adr2 dat00000055", ok, oa, last_wadr, last_wdat); end
  endtask

  task automatic test_back_to_back();
    logic ok, e2, st, ba; logic [AW-1:0] a1; logic [DW-1:0] oa, ob; int wl;
    logic [DW-1:0] r1, r2;
    r1 = $urandom; r2 = $urandom;
    run_instr(12'd9, 12'd9, 12'd9, 1'b1, 1'b1, 0, 0, r1, 1'b0, ok, e2, a1, oa, ob, st, ba, wl);
    checks++; if (oa !== model[9] || ob !== model[9]) begin
      failures++; $display("FAIL b2b_first got=%h/%h exp=%h", oa, ob, model[9]); end
    model[9] = r1;
    run_instr(12'd9, 12'd9, 12'd9, 1'b1, 1'b1, 0, 0, r2, 1'b0, ok, e2, a1, oa, ob, st, ba, wl);
    checks++; if (ok !== 1'b1 || oa !== r1 || ob !== r1) begin
      failures++; $display("FAIL b2b_second got=%h/%h exp=%h", oa, ob, r1); end
    model[9] = r2;
  endtask

  task automatic test_random();
    logic ok, e2, st, ba; logic [AW-1:0] a1; logic [DW-1:0] oa, ob; int wl, w0, nerr;
    logic [AW-1:0] s1, s2, d; logic u, w; logic [DW-1:0] r, ea, eb;
    nerr = 0;
    for (int i = 0; i < 40; i++) begin
      s1 = AW'($urandom_range(15)); s2 = AW'($urandom_range(15)); d = AW'($urandom_range(15));
      u = 1'($urandom_range(1)); w = 1'($urandom_range(1)); r = $urandom;
      ea = model[s1]; eb = u ? model[s2] : '0;
      w0 = wcount;
      run_instr(s1, s2, d, u, w, $urandom_range(3), $urandom_range(3), r, 1'b0, ok, e2, a1, oa, ob, st, ba, wl);
      if (w) model[d] = r;
      checks++;
      if (ok !== 1'b1 || oa !== ea || ob !== eb || st !== 1'b1 ||
          (wcount - w0) !== (w ? 1 : 0) || (w && (last_wadr !== d || last_wdat !== r))) begin
        failures++; nerr++;
        if (nerr <= 5)
          $display("FAIL random_%0d got=ok%b ops=%h/%h wr=%0d adr%0d dat%h exp=ops=%h/%h wr=%0d adr%0d dat%h",
                   i, ok, oa, ob, wcount - w0, last_wadr, last_wdat, ea, eb, w ? 1 : 0, d, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_no_rs2();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_access_seq.md
Name: regfile_access_seq

Overview:
Requester-side sequencer for the processor's dual-read/single-write register file. It accepts one decoded instruction (rs1, rs2, rd, flags) and drives the register-file read enables and addresses. It captures both operands, hands them to the ALU over a valid/ready handshake, then writes the ALU result back to rd. Its rf_* ports connect directly to the register file; it runs on posedge clk, while the register file samples on negedge.

Parameters:
DATA_WIDTH, 32, register/operand width
ADDRESS_WIDTH, 12, register-file address width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  high only in IDLE
instr_rs1  in  ADDRESS_WIDTH  source register 1
instr_rs2  in  ADDRESS_WIDTH  source register 2
instr_rd  in  ADDRESS_WIDTH  destination register
instr_use_rs2  in  1  second operand needed
instr_wb  in  1  result written back to rd
op_valid  out  1  operands valid to ALU
op_ready  in  1  ALU accepts operands
op_a  out  DATA_WIDTH  operand A
op_b  out  DATA_WIDTH  operand B, 0 when rs2 unused
res_valid  in  1  ALU result valid
res_ready  out  1  high only in WAIT_RES
res_data  in  DATA_WIDTH  ALU result
rf_r_en_one  out  1  register-file read enable, port one
rf_r_en_two  out  1  register-file read enable, port two
rf_r_adrs_one  out  ADDRESS_WIDTH  read address, port one
rf_r_adrs_two  out  ADDRESS_WIDTH  read address, port two
rf_r_data_one  in  DATA_WIDTH  read data, port one (registered in RF on negedge)
rf_r_data_two  in  DATA_WIDTH  read data, port two
rf_w_en  out  1  register-file write enable
rf_w_adrs  out  ADDRESS_WIDTH  write address
rf_w_data  out  DATA_WIDTH  write data
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, immediately (async). op_a, op_b and the latched instruction fields clear to 0; the result register clears to 0. All enables and valids are 0; instr_ready=1.
- FSM states: IDLE, READ, ISSUE, WAIT_RES, WRITE. All rf_* outputs decode from registered state and latched fields only, so they are stable across the negedge.
- IDLE: on instr_valid&&instr_ready, latch rs1/rs2/rd/use_rs2/wb and go to READ.
- READ: exactly one cycle. rf_r_en_one=1; rf_r_en_two=use_rs2; addresses come from the latched fields.
  - The register file samples at the mid-cycle negedge.
  - At the closing posedge: op_a<=rf_r_data_one; op_b<=use_rs2 ? rf_r_data_two : 0. Go to ISSUE.
- ISSUE: op_valid=1, with op_a and op_b held stable until op_ready. On op_ready, go to WAIT_RES if wb, else IDLE.
- WAIT_RES: res_ready=1. On res_valid, latch res_data and go to WRITE. A res_valid seen in any other state is ignored.
- WRITE: exactly one cycle. rf_w_en=1, rf_w_adrs=rd, rf_w_data=latched result; the register file writes at the negedge. Go to IDLE.
- Latency:
  - With wb: instruction accept to rf_w_en = 3 cycles plus ALU handshake stalls. Minimum 5-cycle occupancy per instruction.
  - Without wb: minimum 3 cycles.
- Read-after-write: the next READ occurs at least 2 posedges after WRITE, so it sees the new value. No bypass is needed.
- rs1==rs2: both ports read the same address; op_a==op_b.
- rd equal to rs1: legal. The read happens before the write.
- instr_valid while busy: ignored, not latched.
- op_ready held high constantly: ISSUE lasts exactly 1 cycle.
- Reset mid-operation:
  - All outputs drop the same cycle.
  - Reset asserted during WRITE before the negedge means no write is issued. The register file also clears on its own reset.
  - An in-flight instruction is discarded and never replayed.

Decomposition:
- Shared package: state enum (IDLE, READ, ISSUE, WAIT_RES, WRITE), DATA_WIDTH/ADDRESS_WIDTH defaults, and an instr_fields struct (rs1, rs2, rd, use_rs2, wb).
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- After reset, issue rs1=3, rs2=4, use_rs2=1, wb=1 -> op_a=op_b=0x0000000F (RF reset value). ALU returns 0x1E -> rf_w_en pulses 1 cycle with adrs=rd, data=0x1E.
- Write reg 5=0xDEADBEEF via instruction, then immediately read rs1=5 -> op_a=0xDEADBEEF with no bypass.
- use_rs2=0, rs2=7 -> rf_r_en_two=0 and op_b=0. Same with wb=0 -> after op_ready FSM returns to IDLE, and rf_w_en is never asserted.
- Hold op_ready=0 for 6 cycles, then res_valid delayed 4 cycles -> op_a/op_b stable, instr_valid ignored, busy=1 throughout, a single write.
- Assert reset asynchronously during WAIT_RES and during WRITE (before negedge) -> outputs 0 at once, no RF write, next instruction executes normally.
- rs1=rs2=rd=9 back-to-back instructions, second accepted the cycle after IDLE returns -> second op_a equals first result.
